// File: rtl/uart_tx_en.sv
// Byte-wide UART transmitter paced by an external bit-rate strobe.
// A one-byte holding register lets the next frame follow the current one with no idle bit.
module uart_tx_en #(
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       bit_en,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    localparam logic PAR_EN    = (PARITY != 0);
    localparam logic PAR_EVEN  = (PARITY == 2);
    localparam logic STOP_LAST = (STOP_BITS == 2);

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       par_bit_q, par_bit_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_full_q, hold_full_d;
    logic       txd_q, txd_d;
    logic       load;
    logic       accept;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_cnt_d  = stop_cnt_q;
        par_bit_d   = par_bit_q;
        hold_data_d = hold_data_q;
        hold_full_d = hold_full_q;
        txd_d       = txd_q;
        load        = 1'b0;
        accept      = tx_valid & ~hold_full_q;

        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        txd_d = 1'b1;
                    end
                end
                S_START: begin
                    state_d = S_DATA;
                    txd_d   = shift_q[0];
                end
                S_DATA: begin
                    if (bit_cnt_q == 3'd7) begin
                        if (PAR_EN) begin
                            state_d = S_PAR;
                            txd_d   = par_bit_q;
                        end else begin
                            state_d    = S_STOP;
                            txd_d      = 1'b1;
                            stop_cnt_d = 1'b0;
                        end
                    end else begin
                        // shift_q[1] becomes the new LSB, so it is the bit now on the line
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
                S_PAR: begin
                    state_d    = S_STOP;
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                S_STOP: begin
                    if (stop_cnt_q == STOP_LAST) begin
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            txd_d   = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                        txd_d      = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end
            endcase
        end

        if (load) begin
            state_d     = S_START;
            txd_d       = 1'b0;
            shift_d     = hold_data_q;
            bit_cnt_d   = 3'd0;
            par_bit_d   = PAR_EVEN ? (^hold_data_q) : (~^hold_data_q);
            hold_full_d = 1'b0;
        end

        // load requires a full holding register and accept an empty one, so they never collide
        if (accept) begin
            hold_full_d = 1'b1;
            hold_data_d = tx_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            shift_q     <= 8'h00;
            bit_cnt_q   <= 3'd0;
            stop_cnt_q  <= 1'b0;
            par_bit_q   <= 1'b0;
            hold_data_q <= 8'h00;
            hold_full_q <= 1'b0;
            txd_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            par_bit_q   <= par_bit_d;
            hold_data_q <= hold_data_d;
            hold_full_q <= hold_full_d;
            txd_q       <= txd_d;
        end
    end

    assign tx_ready = ~hold_full_q;
    assign txd      = txd_q;
    assign busy     = (state_q != S_IDLE) | hold_full_q;

endmodule

// File: tb/tb_uart_tx_en.sv
// Bench for uart_tx_en: five parity/stop configurations driven side by side and
// compared every cycle against a frame-level model of the serial line.
module tb_uart_tx_en;

    localparam int N = 5;

    function automatic int par_cfg(input int k);
        case (k)
            1:       return 1;
            2, 4:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_cfg(input int k);
        return (k == 3 || k == 4) ? 2 : 1;
    endfunction

    logic         clk_in = 1'b0;
    logic         rst_n  = 1'b0;
    logic         bit_en = 1'b0;
    logic [N-1:0] tx_valid_v = '0;
    logic [7:0]   tx_data_a [N];
    logic [N-1:0] tx_ready_v;
    logic [N-1:0] txd_v;
    logic [N-1:0] busy_v;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_in = ~clk_in;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_tx_en #(
            .PARITY   (par_cfg(g)),
            .STOP_BITS(stop_cfg(g))
        ) u_dut (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .bit_en  (bit_en),
            .tx_data (tx_data_a[g]),
            .tx_valid(tx_valid_v[g]),
            .tx_ready(tx_ready_v[g]),
            .txd     (txd_v[g]),
            .busy    (busy_v[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Line bit i of a frame for byte b under the parity/stop settings of instance k.
    function automatic logic frame_bit(input logic [7:0] b, input int k, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
        if (par_cfg(k) != 0 && i == 9) return (par_cfg(k) == 2) ? ^b : ~^b;
        return 1'b1;
    endfunction

    function automatic int frame_len(input int k);
        return 9 + ((par_cfg(k) != 0) ? 1 : 0) + stop_cfg(k);
    endfunction

    // Reference model: one-byte buffer plus the frame currently on the line.
    logic       m_full   [N];
    logic [7:0] m_hold   [N];
    logic [7:0] m_cur    [N];
    logic       m_active [N];
    int         m_idx    [N];
    logic       m_line   [N];
    int         acc_cnt  [N];

    initial begin
        for (int k = 0; k < N; k++) begin
            acc_cnt[k]   = 0;
            tx_data_a[k] = 8'h00;
        end
    end

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N; k++) begin
                m_full[k]   = 1'b0;
                m_hold[k]   = 8'h00;
                m_cur[k]    = 8'h00;
                m_active[k] = 1'b0;
                m_idx[k]    = 0;
                m_line[k]   = 1'b1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                logic acc;
                acc = tx_valid_v[k] && !m_full[k];
                if (bit_en) begin
                    if (!m_active[k] || m_idx[k] == frame_len(k)) begin
                        if (m_full[k]) begin
                            m_full[k]   = 1'b0;
                            m_cur[k]    = m_hold[k];
                            m_active[k] = 1'b1;
                            m_idx[k]    = 1;
                            m_line[k]   = 1'b0;
                        end else begin
                            m_active[k] = 1'b0;
                            m_line[k]   = 1'b1;
                        end
                    end else begin
                        m_line[k] = frame_bit(m_cur[k], k, m_idx[k]);
                        m_idx[k]  = m_idx[k] + 1;
                    end
                end
                if (acc) begin
                    m_full[k]  = 1'b1;
                    m_hold[k]  = tx_data_a[k];
                    acc_cnt[k] = acc_cnt[k] + 1;
                end
            end
            #1;
            for (int k = 0; k < N; k++) begin
                check_eq($sformatf("txd[%0d]", k), 32'(txd_v[k]), 32'(m_line[k]));
                check_eq($sformatf("tx_ready[%0d]", k), 32'(tx_ready_v[k]), 32'(!m_full[k]));
                check_eq($sformatf("busy[%0d]", k), 32'(busy_v[k]), 32'(m_active[k] || m_full[k]));
            end
        end
    end

    // Strobe generator: mode 0 = fixed divider, mode 1 = random spacing.
    int en_mode = 0;
    int div     = 16;

    initial begin
        int div_cnt;
        div_cnt = 0;
        forever begin
            @(negedge clk_in);
            if (en_mode == 0) begin
                div_cnt = (div_cnt + 1) % div;
                bit_en  = (div_cnt == 0);
            end else begin
                bit_en = ($urandom_range(2) == 0);
            end
        end
    end

    logic [7:0] nb [N];

    task automatic send_all();
        int           base [N];
        logic [N-1:0] done;
        done = '0;
        @(negedge clk_in);
        for (int k = 0; k < N; k++) begin
            base[k]       = acc_cnt[k];
            tx_data_a[k]  = nb[k];
            tx_valid_v[k] = 1'b1;
        end
        for (int c = 0; c < 3000 && done != '1; c++) begin
            @(negedge clk_in);
            for (int k = 0; k < N; k++) begin
                if (!done[k] && acc_cnt[k] != base[k]) begin
                    done[k]       = 1'b1;
                    tx_valid_v[k] = 1'b0;
                end
            end
        end
        tx_valid_v = '0;
        for (int k = 0; k < N; k++) check_eq($sformatf("accepted[%0d]", k), 32'(done[k]), 32'd1);
    endtask

    task automatic send_same(input logic [7:0] b);
        for (int k = 0; k < N; k++) nb[k] = b;
        send_all();
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int c = 0; c < 5000 && !idle; c++) begin
            @(negedge clk_in);
            idle = 1'b1;
            for (int k = 0; k < N; k++) if (m_active[k] || m_full[k]) idle = 1'b0;
        end
        check_eq("idle_reached", 32'(idle), 32'd1);
    endtask

    initial begin
        logic        found;
        logic [10:0] cap;

        repeat (3) @(negedge clk_in);
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("rst_txd[%0d]", k), 32'(txd_v[k]), 32'd1);
            check_eq($sformatf("rst_ready[%0d]", k), 32'(tx_ready_v[k]), 32'd1);
            check_eq($sformatf("rst_busy[%0d]", k), 32'(busy_v[k]), 32'd0);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk_in);

        send_same(8'h55); wait_idle();
        send_same(8'h03); wait_idle();
        send_same(8'h80); wait_idle();
        send_same(8'hFF); wait_idle();

        send_same(8'hA5);
        send_same(8'h3C);
        wait_idle();

        // Reset while bit 4 of 0x0F is on the line (line index 5 means model index 6).
        send_same(8'h0F);
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk_in);
            if (m_active[0] && m_idx[0] == 6) found = 1'b1;
        end
        check_eq("reached_bit4", 32'(found), 32'd1);
        repeat (3) @(negedge clk_in);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < N; k++) begin
            check_eq($sformatf("midrst_txd[%0d]", k), 32'(txd_v[k]), 32'd1);
            check_eq($sformatf("midrst_ready[%0d]", k), 32'(tx_ready_v[k]), 32'd1);
            check_eq($sformatf("midrst_busy[%0d]", k), 32'(busy_v[k]), 32'd0);
        end
        repeat (2) @(negedge clk_in);
        rst_n = 1'b1;
        send_same(8'h81); wait_idle();

        // Continuous strobe: instance 2 is even parity, one stop bit.
        div = 1;
        repeat (5) @(negedge clk_in);
        send_same(8'hC3);
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(posedge clk_in);
            #2;
            if (txd_v[2] === 1'b0) found = 1'b1;
        end
        check_eq("cont_start_found", 32'(found), 32'd1);
        cap = 11'b0;
        cap = {cap[9:0], txd_v[2]};
        for (int i = 1; i < 11; i++) begin
            @(posedge clk_in);
            #2;
            cap = {cap[9:0], txd_v[2]};
        end
        check_eq("cont_frame_c3", 32'(cap), 32'(11'b01100001101));
        wait_idle();

        en_mode = 1;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < N; k++) nb[k] = 8'($urandom);
            send_all();
            if ($urandom_range(3) == 0) repeat ($urandom_range(60)) @(negedge clk_in);
        end
        wait_idle();

        en_mode = 0;
        div     = 3;
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < N; k++) nb[k] = 8'($urandom);
            send_all();
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_en.md
# uart_tx_en

- Serial UART-style transmitter for the verification-platform controller.
- Consumes the single-cycle `en` pulse produced by the platform's bit-rate enable divider. Serialises bytes offered on a valid/ready handshake into frames on `txd`: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Holds one byte in a holding register, so a second byte can be accepted while a frame is in flight and frames go out back-to-back without idle bits.

## Interface
- `PARITY`, default 0: parity mode. 0 = none, 1 = odd, 2 = even. Value 3 is illegal.
- `STOP_BITS`, default 1: stop-bit count. Legal values are 1 or 2.
- `clk_in`  input  1  system clock. All logic is on the rising edge.
- `rst_n`  input  1  reset. One clock; reset is asynchronous and active-low.
- `bit_en`  input  1  one-cycle bit-period strobe from the enable divider. May be high continuously, giving one bit per clock.
- `tx_data`  input  8  byte to send. Sampled only on handshake.
- `tx_valid`  input  1  `tx_data` is valid.
- `tx_ready`  output  1  holding register is empty; byte accepted when `tx_valid & tx_ready`.
- `txd`  output  1  serial line. Registered, idles high.
- `busy`  output  1  frame in progress or byte pending.

## Operation
- **Holding register**
  - Contents: `hold_data[7:0]` and `hold_full`.
  - `tx_ready = ~hold_full`, derived from the register only, with no combinational path from `tx_valid`.
  - Handshake sets `hold_full` and captures `tx_data`.
  - Drain to the shifter clears `hold_full`. A drain only occurs when `hold_full = 1`, so accept and drain can never coincide.
- **State machine**: states IDLE, START, DATA, PAR, STOP. All transitions and all `txd` updates occur only on cycles with `bit_en = 1`.
  - IDLE, `hold_full = 1`: go to START. Drive `txd = 0`, load the shifter from `hold_data`, clear `hold_full`, clear the bit counter.
  - IDLE, `hold_full = 0`: stay in IDLE, `txd = 1`.
  - START: go to DATA and drive `txd = shift[0]`.
  - DATA: on each strobe, shift right and increment the 3-bit counter.
    - After bit 7 has occupied its period, go to PAR if `PARITY != 0`, otherwise to STOP.
    - On entering PAR, drive the parity bit. On entering STOP, drive `txd = 1`.
    - Parity is computed over the loaded byte: even → `^byte`, odd → `~^byte`.
  - PAR: go to STOP, `txd = 1`.
  - STOP: holds for `STOP_BITS` periods (1-bit stop counter). After the last period:
    - if `hold_full = 1`, go directly to START (drive `txd = 0`, load the shifter, clear `hold_full`);
    - otherwise go to IDLE.
- **Frame length**: `1 + 8 + (PARITY != 0) + STOP_BITS` bit periods.
- **busy**: `(state != IDLE) | hold_full`, registered or derived from registers.
- **Reset values**
  - `txd = 1`, `tx_ready = 1`, `busy = 0`.
  - State IDLE, holding register empty, counters 0.
- **Reset mid-frame**: `txd` returns high asynchronously, the partially sent byte and the pending byte are discarded, and no residue remains after release.
- **Strobe pattern**: `bit_en` during IDLE with nothing pending has no effect. The bit period is whatever spacing `bit_en` presents; no gap-length check is made.

## Timing
- Handshake in cycle t, block in IDLE: the start bit appears on `txd` the cycle after the next `bit_en`, i.e. at most one divider period plus 1 clock.
- Each bit stays on `txd` from the cycle after strobe k until the cycle after strobe k+1.
- Back-to-back bytes: the start bit of byte 2 follows the last stop bit of byte 1 with no idle bit, provided byte 2 was accepted before the final STOP strobe.
- Timing of `tx_ready`:
  - goes high 1 cycle after the drain strobe;
  - goes low 1 cycle after a handshake.
- Continuous `bit_en`: one bit per clock; the frame still honours all rules above.

## Test plan
- **Basic frame**: `PARITY=0`, `STOP_BITS=1`, divider period 16, send 0x55. Required: `txd` = 0,1,0,1,0,1,0,1,0,1, each bit held 16 clocks; `busy` falls after the stop bit.
- **Parity**: send 0x03 with `PARITY=2` → parity bit 0. Send 0x03 with `PARITY=1` → parity bit 1. Send 0x80 with `PARITY=2` → parity bit 1.
- **Two stop bits**: `STOP_BITS=2`, send 0xFF. Required: 1 start bit (0), then 10 consecutive high periods.
- **Back-to-back**:
  - Offer 0xA5 then 0x3C with `tx_valid` held high.
  - Required: `tx_ready` drops after the first accept and rises at the start of the 0xA5 frame; the second byte is accepted.
  - Required: 20 bit periods of frames with no idle bit between them; `tx_ready` stays low while both registers are occupied.
- **Reset mid-frame**: assert `rst_n` low during DATA bit 4 of 0x0F. Required: `txd = 1` immediately, `tx_ready = 1`, `busy = 0`. The next byte, 0x81, is sent cleanly with no remnant of 0x0F.
- **Continuous `bit_en`**: hold `bit_en = 1` and send 0xC3 with `PARITY=2`. Required: an 11-clock frame of 0,1,1,0,0,0,0,1,1,0,1.
